// File: rtl/memu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memu_pkg
// Purpose  : Shared definitions for the MEM stage: load/store funct3
//            encodings, FSM state encoding and small helper functions.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package memu_pkg;

    // Load funct3 encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store funct3 encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    // MEM stage FSM states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } state_e;

    // Byte offset inside the 64-bit word converted to a bit shift amount.
    function automatic logic [5:0] byte_to_bit_shift(input logic [2:0] offset);
        return {offset, 3'b000};
    endfunction

endpackage : memu_pkg
`default_nettype wire

// File: rtl/memu_align.sv
`default_nettype none
// ============================================================================
// Module   : mem_align
// Purpose  : Purely combinational data alignment for the MEM stage.
//            - store byte-lane mask and replicated write data
//            - load extract (shift by byte offset) and sign/zero extension
//            - misalignment check for an incoming access
// Ports    :
//   funct3     in  3   access type of the latched instruction
//   offset     in  3   byte offset (addr[2:0]) of the latched instruction
//   store_src  in  64  rs2 value to be stored
//   load_raw   in  64  raw read data from the bus
//   chk_funct3 in  3   access type of the instruction being accepted
//   chk_offset in  3   byte offset of the instruction being accepted
//   wmask      out 8   byte-lane write mask
//   wdata      out 64  replicated store data
//   load_data  out 64  aligned and extended load result
//   misalign   out 1   incoming access is not naturally aligned
// Revision : 1.0 - initial release
// ============================================================================
module mem_align
    import memu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [2:0]  offset,
    input  logic [63:0] store_src,
    input  logic [63:0] load_raw,
    input  logic [2:0]  chk_funct3,
    input  logic [2:0]  chk_offset,
    output logic [7:0]  wmask,
    output logic [63:0] wdata,
    output logic [63:0] load_data,
    output logic        misalign
);

    logic [63:0] shifted;

    assign shifted = load_raw >> byte_to_bit_shift(offset);

    // Store side: data is replicated across all lanes so the mask alone
    // selects the bytes written, whatever the offset.
    always_comb begin
        wmask = 8'hFF;
        wdata = store_src;
        case (funct3)
            F3_SB: begin
                wmask = 8'h01 << offset;
                wdata = {8{store_src[7:0]}};
            end
            F3_SH: begin
                wmask = 8'h03 << offset;
                wdata = {4{store_src[15:0]}};
            end
            F3_SW: begin
                wmask = 8'h0F << offset;
                wdata = {2{store_src[31:0]}};
            end
            F3_SD: begin
                wmask = 8'hFF;
                wdata = store_src;
            end
            default: begin
                wmask = 8'hFF;
                wdata = store_src;
            end
        endcase
    end

    // Load side
    always_comb begin
        load_data = shifted;
        case (funct3)
            F3_LB:   load_data = {{56{shifted[7]}},  shifted[7:0]};
            F3_LBU:  load_data = {56'd0,             shifted[7:0]};
            F3_LH:   load_data = {{48{shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_data = {48'd0,             shifted[15:0]};
            F3_LW:   load_data = {{32{shifted[31]}}, shifted[31:0]};
            F3_LWU:  load_data = {32'd0,             shifted[31:0]};
            F3_LD:   load_data = shifted;
            default: load_data = shifted;
        endcase
    end

    // Natural alignment: the size field is shared between loads and stores,
    // so the load encodings cover the store ones as well.
    always_comb begin
        misalign = 1'b0;
        case (chk_funct3)
            F3_LB, F3_LBU: misalign = 1'b0;
            F3_LH, F3_LHU: misalign = chk_offset[0];
            F3_LW, F3_LWU: misalign = |chk_offset[1:0];
            default:       misalign = |chk_offset;
        endcase
    end

endmodule : mem_align
`default_nettype wire

// File: rtl/memu.sv
`default_nettype none
// ============================================================================
// Module   : memu
// Purpose  : Memory-access stage of the RV64 pipeline. Accepts one
//            instruction per cycle from EX, runs load/store transactions
//            on the data bus (valid/ready request, separate rvalid
//            response), aligns load data and registers the MEM/WB fields.
// Ports    :
//   clk, rst_n              clock, synchronous active-low reset
//   i_valid / o_ready       EX handshake
//   i_mem_read/i_mem_write  load / store flags
//   i_funct3                access size and signedness
//   i_alu_result            address (memory ops) or rd data
//   i_rs2_data              store data
//   i_rd_addr, i_rd_wen     destination register
//   o_dmem_*                bus request (valid, addr, wen, wdata, wmask)
//   i_dmem_ready            bus request accepted
//   i_dmem_rvalid/rdata     bus read response
//   o_wb_valid              one-cycle pulse per retired instruction
//   o_rd_*, o_mem_read,
//   o_mem_rdata, o_misalign registered MEM/WB fields
// Revision : 1.0 - initial release
// ============================================================================
module memu
    import memu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [2:0]  i_funct3,
    input  logic [63:0] i_alu_result,
    input  logic [63:0] i_rs2_data,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_rd_wen,
    output logic        o_dmem_valid,
    input  logic        i_dmem_ready,
    output logic [63:0] o_dmem_addr,
    output logic        o_dmem_wen,
    output logic [63:0] o_dmem_wdata,
    output logic [7:0]  o_dmem_wmask,
    input  logic        i_dmem_rvalid,
    input  logic [63:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_rd_wen,
    output logic [4:0]  o_rd_addr,
    output logic [63:0] o_rd_data,
    output logic        o_mem_read,
    output logic [63:0] o_mem_rdata,
    output logic        o_misalign
);

    state_e      state;

    // Instruction latched at accept time for the duration of the access
    logic [63:0] lat_addr;
    logic [63:0] lat_rs2;
    logic [2:0]  lat_funct3;
    logic [4:0]  lat_rd_addr;
    logic        lat_rd_wen;
    logic        lat_is_load;

    logic        accept;
    logic        in_is_mem;
    logic        in_req;
    logic        in_misalign;
    logic [7:0]  al_wmask;
    logic [63:0] al_wdata;
    logic [63:0] al_load;

    assign o_ready   = (state == ST_IDLE);
    assign in_req    = (state == ST_REQ);
    assign accept    = i_valid && o_ready;
    assign in_is_mem = i_mem_read || i_mem_write;

    mem_align u_align (
        .funct3     (lat_funct3),
        .offset     (lat_addr[2:0]),
        .store_src  (lat_rs2),
        .load_raw   (i_dmem_rdata),
        .chk_funct3 (i_funct3),
        .chk_offset (i_alu_result[2:0]),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .load_data  (al_load),
        .misalign   (in_misalign)
    );

    // Bus request is driven from latched state only, so it stays stable
    // while ready is low; outside REQ every request field reads as zero.
    assign o_dmem_valid = in_req;
    assign o_dmem_addr  = in_req ? {lat_addr[63:3], 3'b000} : 64'd0;
    assign o_dmem_wen   = in_req && !lat_is_load;
    assign o_dmem_wdata = in_req ? al_wdata : 64'd0;
    assign o_dmem_wmask = in_req ? al_wmask : 8'd0;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            lat_addr    <= 64'd0;
            lat_rs2     <= 64'd0;
            lat_funct3  <= 3'd0;
            lat_rd_addr <= 5'd0;
            lat_rd_wen  <= 1'b0;
            lat_is_load <= 1'b0;
            o_wb_valid  <= 1'b0;
            o_rd_wen    <= 1'b0;
            o_rd_addr   <= 5'd0;
            o_rd_data   <= 64'd0;
            o_mem_read  <= 1'b0;
            o_mem_rdata <= 64'd0;
            o_misalign  <= 1'b0;
        end else begin
            // Pulses default low; data fields hold their last value
            o_wb_valid <= 1'b0;
            o_rd_wen   <= 1'b0;
            o_misalign <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!in_is_mem) begin
                            o_wb_valid <= 1'b1;
                            o_rd_wen   <= i_rd_wen;
                            o_rd_addr  <= i_rd_addr;
                            o_rd_data  <= i_alu_result;
                            o_mem_read <= 1'b0;
                        end else begin
                            lat_addr    <= i_alu_result;
                            lat_rs2     <= i_rs2_data;
                            lat_funct3  <= i_funct3;
                            lat_rd_addr <= i_rd_addr;
                            lat_rd_wen  <= i_rd_wen;
                            lat_is_load <= i_mem_read;
                            if (in_misalign) begin
                                // Retire immediately as a trap marker, no bus access
                                o_wb_valid <= 1'b1;
                                o_misalign <= 1'b1;
                            end else begin
                                state <= ST_REQ;
                            end
                        end
                    end
                end

                ST_REQ: begin
                    if (i_dmem_ready) begin
                        if (lat_is_load) begin
                            state <= ST_WAIT_R;
                        end else begin
                            state      <= ST_IDLE;
                            o_wb_valid <= 1'b1;
                        end
                    end
                end

                ST_WAIT_R: begin
                    if (i_dmem_rvalid) begin
                        state       <= ST_IDLE;
                        o_wb_valid  <= 1'b1;
                        o_rd_wen    <= lat_rd_wen;
                        o_rd_addr   <= lat_rd_addr;
                        o_rd_data   <= lat_addr;
                        o_mem_read  <= 1'b1;
                        o_mem_rdata <= al_load;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule : memu
`default_nettype wire

// File: tb/tb_memu.sv
`default_nettype none
// ============================================================================
// Module   : tb_memu
// Purpose  : Self-checking bench for memu. Directed scenarios followed by
//            randomized instruction mixes, checked against a byte-level
//            memory model and arithmetic load/store rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_mem_read = 1'b0;
    logic        i_mem_write = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [63:0] i_alu_result = 64'd0;
    logic [63:0] i_rs2_data = 64'd0;
    logic [4:0]  i_rd_addr = 5'd0;
    logic        i_rd_wen = 1'b0;
    logic        o_dmem_valid;
    logic        i_dmem_ready = 1'b0;
    logic [63:0] o_dmem_addr;
    logic        o_dmem_wen;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_wmask;
    logic        i_dmem_rvalid = 1'b0;
    logic [63:0] i_dmem_rdata = 64'd0;
    logic        o_wb_valid;
    logic        o_rd_wen;
    logic [4:0]  o_rd_addr;
    logic [63:0] o_rd_data;
    logic        o_mem_read;
    logic [63:0] o_mem_rdata;
    logic        o_misalign;

    int n_checks = 0;
    int n_errors = 0;

    // Word-addressed model of the data memory, indexed by addr[8:3]
    logic [63:0] mem [0:63];

    always #5 clk = ~clk;

    memu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_valid       (i_valid),
        .o_ready       (o_ready),
        .i_mem_read    (i_mem_read),
        .i_mem_write   (i_mem_write),
        .i_funct3      (i_funct3),
        .i_alu_result  (i_alu_result),
        .i_rs2_data    (i_rs2_data),
        .i_rd_addr     (i_rd_addr),
        .i_rd_wen      (i_rd_wen),
        .o_dmem_valid  (o_dmem_valid),
        .i_dmem_ready  (i_dmem_ready),
        .o_dmem_addr   (o_dmem_addr),
        .o_dmem_wen    (o_dmem_wen),
        .o_dmem_wdata  (o_dmem_wdata),
        .o_dmem_wmask  (o_dmem_wmask),
        .i_dmem_rvalid (i_dmem_rvalid),
        .i_dmem_rdata  (i_dmem_rdata),
        .o_wb_valid    (o_wb_valid),
        .o_rd_wen      (o_rd_wen),
        .o_rd_addr     (o_rd_addr),
        .o_rd_data     (o_rd_data),
        .o_mem_read    (o_mem_read),
        .o_mem_rdata   (o_mem_rdata),
        .o_misalign    (o_misalign)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference rules ----------------
    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit ref_misaligned(input logic [2:0] f3, input logic [63:0] a);
        return (int'(a[2:0]) % acc_size(f3)) != 0;
    endfunction

    function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a,
                                             input logic [63:0] word);
        int          sz;
        logic [63:0] v;
        logic [63:0] keep;
        sz = acc_size(f3);
        v  = word >> (int'(a[2:0]) * 8);
        if (sz == 8) return v;
        keep = (64'd1 << (8 * sz)) - 64'd1;
        v    = v & keep;
        if (!f3[2] && v[8 * sz - 1]) v = v | ~keep;
        return v;
    endfunction

    function automatic logic [7:0] ref_wmask(input logic [2:0] f3, input logic [63:0] a);
        int m;
        m = ((1 << acc_size(f3)) - 1) << int'(a[2:0]);
        return m[7:0];
    endfunction

    function automatic logic [63:0] ref_wdata(input logic [2:0] f3, input logic [63:0] rs2);
        logic [63:0] d;
        int          sz;
        sz = acc_size(f3);
        d  = 64'd0;
        for (int i = 0; i < 8; i++) d[8 * i +: 8] = rs2[8 * (i % sz) +: 8];
        return d;
    endfunction

    // ---------------- one instruction, cycle-scripted ----------------
    // Entered and left at 1 time unit after a rising edge.
    task automatic run_instr(input bit rd_op, input bit wr_op, input logic [2:0] f3,
                             input logic [63:0] a, input logic [63:0] rs2,
                             input logic [4:0] rd, input bit wen,
                             input int req_wait, input int resp_wait,
                             input bit hold_add, input logic [63:0] add_val);
        bit          mis;
        logic [63:0] wd;
        logic [7:0]  wm;
        mis = (rd_op || wr_op) && ref_misaligned(f3, a);
        wm  = ref_wmask(f3, a);
        wd  = ref_wdata(f3, rs2);

        check("ready_idle", o_ready, 1);
        i_valid      = 1'b1;
        i_mem_read   = rd_op;
        i_mem_write  = wr_op;
        i_funct3     = f3;
        i_alu_result = a;
        i_rs2_data   = rs2;
        i_rd_addr    = rd;
        i_rd_wen     = wen;
        @(posedge clk); #1;
        if (hold_add) begin
            i_mem_read   = 1'b0;
            i_mem_write  = 1'b0;
            i_alu_result = add_val;
            i_rd_addr    = 5'd9;
            i_rd_wen     = 1'b1;
        end else begin
            i_valid = 1'b0;
        end

        if (!(rd_op || wr_op) || mis) begin
            check("wb_valid_1cyc", o_wb_valid, 1);
            check("misalign", o_misalign, mis);
            check("no_bus_req", o_dmem_valid, 0);
            check("rd_wen_1cyc", o_rd_wen, mis ? 1'b0 : wen);
            if (!mis) begin
                check("rd_addr", o_rd_addr, rd);
                check("rd_data", o_rd_data, a);
                check("mem_read0", o_mem_read, 0);
            end
        end else begin
            for (int w = 0; w <= req_wait; w++) begin
                check("dmem_valid", o_dmem_valid, 1);
                check("dmem_addr", o_dmem_addr, {a[63:3], 3'b000});
                check("dmem_wen", o_dmem_wen, wr_op);
                check("ready_busy", o_ready, 0);
                check("no_wb_req", o_wb_valid, 0);
                check("rd_wen_idle", o_rd_wen, 0);
                if (wr_op) begin
                    check("wmask", o_dmem_wmask, wm);
                    check("wdata", o_dmem_wdata, wd);
                end
                i_dmem_ready = (w == req_wait);
                @(posedge clk); #1;
            end
            i_dmem_ready = 1'b0;
            if (wr_op) begin
                check("st_wb_valid", o_wb_valid, 1);
                check("st_rd_wen", o_rd_wen, 0);
                check("st_misalign", o_misalign, 0);
                for (int i = 0; i < 8; i++)
                    if (wm[i]) mem[a[8:3]][8 * i +: 8] = wd[8 * i +: 8];
            end else begin
                for (int w = 0; w <= resp_wait; w++) begin
                    check("wr_no_valid", o_dmem_valid, 0);
                    check("wr_no_wb", o_wb_valid, 0);
                    check("wr_busy", o_ready, 0);
                    i_dmem_rvalid = (w == resp_wait);
                    i_dmem_rdata  = (w == resp_wait) ? mem[a[8:3]] : {$urandom, $urandom};
                    @(posedge clk); #1;
                end
                i_dmem_rvalid = 1'b0;
                check("ld_wb_valid", o_wb_valid, 1);
                check("ld_mem_read", o_mem_read, 1);
                check("ld_rdata", o_mem_rdata, ref_load(f3, a, mem[a[8:3]]));
                check("ld_rd_wen", o_rd_wen, wen);
                check("ld_rd_addr", o_rd_addr, rd);
                check("ld_misalign", o_misalign, 0);
            end
        end

        if (hold_add) begin
            check("held_ready", o_ready, 1);
            @(posedge clk); #1;
            i_valid = 1'b0;
            check("held_wb", o_wb_valid, 1);
            check("held_rd_data", o_rd_data, add_val);
            check("held_rd_addr", o_rd_addr, 5'd9);
        end
    endtask

    initial begin
        bit          rd_op;
        bit          wr_op;
        logic [2:0]  f3;
        logic [63:0] a;
        int          kind;

        for (int i = 0; i < 64; i++) mem[i] = {$urandom, $urandom};

        // Reset state
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", o_ready, 1);
        check("rst_wb_valid", o_wb_valid, 0);
        check("rst_dmem_valid", o_dmem_valid, 0);
        check("rst_dmem_addr", o_dmem_addr, 0);
        check("rst_wmask", o_dmem_wmask, 0);
        check("rst_rd_data", o_rd_data, 0);
        check("rst_mem_rdata", o_mem_rdata, 0);
        rst_n = 1'b1;

        // Back-to-back non-memory instructions
        for (int i = 0; i < 4; i++)
            run_instr(0, 0, 3'd0, 64'h1234, 64'd0, 5'd5, 1, 0, 0, 0, 64'd0);

        // SB with a two-cycle ready wait
        run_instr(0, 1, 3'b000, 64'h1003, 64'hAB, 5'd3, 1, 2, 0, 0, 64'd0);

        // Sign/zero extension cases
        mem[0] = 64'h0000_80FF_0000_0000;
        run_instr(1, 0, 3'b000, 64'h2005, 64'd0, 5'd7, 1, 0, 0, 0, 64'd0);
        check("lb_const", o_mem_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_instr(1, 0, 3'b100, 64'h2005, 64'd0, 5'd7, 1, 1, 2, 0, 64'd0);
        check("lbu_const", o_mem_rdata, 64'h80);
        run_instr(1, 0, 3'b110, 64'h2004, 64'd0, 5'd8, 1, 0, 1, 0, 64'd0);

        // Misaligned LW, then aligned LD
        run_instr(1, 0, 3'b010, 64'h3002, 64'd0, 5'd4, 1, 0, 0, 0, 64'd0);
        run_instr(1, 0, 3'b011, 64'h3008, 64'd0, 5'd4, 1, 1, 1, 0, 64'd0);

        // EX holds a second instruction while the load is outstanding
        run_instr(1, 0, 3'b001, 64'h2006, 64'd0, 5'd2, 1, 1, 3, 1, 64'hCAFE_F00D);

        // Reset during WAIT_R, followed by a stray response
        i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
        i_funct3 = 3'b011; i_alu_result = 64'h3008; i_rd_addr = 5'd6; i_rd_wen = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_dmem_ready = 1'b1;
        @(posedge clk); #1;
        i_dmem_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rstmid_dmem_valid", o_dmem_valid, 0);
        check("rstmid_ready", o_ready, 1);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b0;
        check("rstmid_wb_valid", o_wb_valid, 0);
        check("rstmid_rd_wen", o_rd_wen, 0);
        check("rstmid_mem_rdata", o_mem_rdata, 0);
        check("rstmid_rd_data", o_rd_data, 0);
        check("rstmid_ready2", o_ready, 1);

        // Randomized mix
        for (int n = 0; n < 80; n++) begin
            kind  = int'($urandom_range(0, 2));
            rd_op = (kind == 1);
            wr_op = (kind == 2);
            f3    = wr_op ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
            a     = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0)
                a = a & ~64'(acc_size(f3) - 1);
            run_instr(rd_op, wr_op, f3, a, {$urandom, $urandom}, 5'($urandom),
                      1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      rd_op && ($urandom_range(0, 3) == 0), {$urandom, $urandom});
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_memu
`default_nettype wire
